// File: rtl/switch_scan_controller.sv
// Switch scan controller: synchronises, debounces and snapshots 24 board switches for CPU MMIO reads.
// Optional change interrupt built only when SWITCH_IRQ_EN is defined.
module switch_scan_controller #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int STABLE_COUNT = 4
) (
    input  logic        iCpuClock,
    input  logic        iCpuResetN,
    input  logic [23:0] iFpgaSwitches,
    input  logic        iDoSwitchRead,
    input  logic [1:0]  iSwitchAddress,
    output logic [15:0] oSwitchDataRead,
    output logic        oSwitchReadValid,
    output logic        oSwitchChanged,
    output logic        oSwitchIrq
);

    localparam int PRESC_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
    localparam logic [8:0] STABLE_LAST = 9'(STABLE_COUNT);

    typedef enum logic {
        S_IDLE,
        S_CONFIRM
    } state_t;

    logic [23:0]        swMeta_p0;
    logic [23:0]        swSync_p1;
    logic [PRESC_W-1:0] prescaler;
    logic               tick;
    state_t             state;
    state_t             stateNext;
    logic [23:0]        candidate;
    logic [23:0]        candidateNext;
    logic [23:0]        stable;
    logic [7:0]         cnt;
    logic [7:0]         cntNext;
    logic [8:0]         cntInc;
    logic               hitCount;
    logic               commit;
    logic               statusRead;

    function automatic logic [15:0] selectWindow(input logic [1:0]  addr,
                                                 input logic [23:0] snap,
                                                 input logic        flag);
        case (addr)
            2'b00:   selectWindow = snap[15:0];
            2'b10:   selectWindow = {8'h00, snap[23:16]};
            2'b01:   selectWindow = {15'h0000, flag};
            default: selectWindow = 16'h0000;
        endcase
    endfunction

    // Stage p0/p1: two-flop synchroniser on the asynchronous pins
    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            swMeta_p0 <= 24'h0;
            swSync_p1 <= 24'h0;
        end else begin
            swMeta_p0 <= iFpgaSwitches;
            swSync_p1 <= swMeta_p0;
        end
    end

    assign tick = (prescaler == PRESC_LAST);

    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign cntInc   = {1'b0, cnt} + 9'd1;
    assign hitCount = (cntInc == STABLE_LAST);

    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            state     <= S_IDLE;
            candidate <= 24'h0;
            cnt       <= 8'd0;
            stable    <= 24'h0;
        end else begin
            state     <= stateNext;
            candidate <= candidateNext;
            cnt       <= cntNext;
            if (commit) begin
                stable <= swSync_p1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (swSync_p1 != stable && STABLE_COUNT > 1) begin
                        stateNext = S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (swSync_p1 == candidate) begin
                        if (hitCount) begin
                            stateNext = S_IDLE;
                        end
                    end else if (swSync_p1 == stable) begin
                        stateNext = S_IDLE;
                    end
                end
                default: stateNext = S_IDLE;
            endcase
        end
    end

    // A commit always latches swSync: in CONFIRM it equals the candidate by construction
    always_comb begin
        candidateNext = candidate;
        cntNext       = cnt;
        commit        = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (swSync_p1 != stable) begin
                        if (STABLE_COUNT == 1) begin
                            commit = 1'b1;
                        end else begin
                            candidateNext = swSync_p1;
                            cntNext       = 8'd1;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (swSync_p1 == candidate) begin
                        cntNext = cntInc[7:0];
                        commit  = hitCount;
                    end else if (swSync_p1 != stable) begin
                        candidateNext = swSync_p1;
                        cntNext       = 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign statusRead = iDoSwitchRead && (iSwitchAddress == 2'b01);

    // Read port: snapshot uses pre-commit stable/changed; a same-edge commit wins the flag
    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            oSwitchReadValid <= 1'b0;
            oSwitchDataRead  <= 16'h0000;
            oSwitchChanged   <= 1'b0;
        end else begin
            oSwitchReadValid <= iDoSwitchRead;
            if (iDoSwitchRead) begin
                oSwitchDataRead <= selectWindow(iSwitchAddress, stable, oSwitchChanged);
            end
            if (commit) begin
                oSwitchChanged <= 1'b1;
            end else if (statusRead) begin
                oSwitchChanged <= 1'b0;
            end
        end
    end

`ifdef SWITCH_IRQ_EN
    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            oSwitchIrq <= 1'b0;
        end else begin
            oSwitchIrq <= commit;
        end
    end
`else
    assign oSwitchIrq = 1'b0;
`endif

endmodule
